// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the system bus arbiter. Holds the
//                arbiter state encoding and the system bus geometry used by
//                the surrounding microcontroller top.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Arbiter states. TURN is the single bus-idle cycle between two tenures
  // that keeps two masters from driving the bidirectional data bus at once.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // System bus widths.
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Base address of the I/O register bank.
  localparam logic [ADDR_W-1:0] IO_BASE_ADDR = 16'h0002;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first set
//                bit of 'eligible' scanning last+1, last+2, ... modulo
//                NUM_REQ. Implemented as rotate, find-first, un-rotate.
//  Revision    : 1.0 - initial release
//
//  Ports
//    eligible  in   NUM_REQ  candidate masters
//    last      in   OWNER_W  index of the most recently granted master
//    pick      out  OWNER_W  selected master index (valid only when valid=1)
//    valid     out  1        at least one eligible master exists
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int OWNER_W = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [OWNER_W-1:0] last,
  output logic [OWNER_W-1:0] pick,
  output logic               valid
);

  logic [NUM_REQ-1:0] rotated;
  int                 start_idx;
  int                 offset;
  int                 sum_idx;
  logic               found;

  always_comb begin
    // Scan origin is the index just after the previous winner.
    start_idx = int'(last) + 1;
    if (start_idx >= NUM_REQ) begin
      start_idx = 0;
    end

    // Rotate right so the scan origin lands on bit 0. Doubling the vector
    // makes the wrap-around bits fall in naturally.
    rotated = NUM_REQ'({eligible, eligible} >> start_idx);

    // Lowest set bit of the rotated vector.
    found  = 1'b0;
    offset = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end

    // Undo the rotation, modulo NUM_REQ (NUM_REQ need not be a power of 2).
    sum_idx = offset + start_idx;
    if (sum_idx >= NUM_REQ) begin
      sum_idx = sum_idx - NUM_REQ;
    end

    pick  = OWNER_W'(sum_idx);
    valid = found;
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter for the shared system address/data bus.
//                Grants one master at a time, force-releases a tenure after
//                MAX_TENURE cycles (locking that master out until it drops
//                its request), and inserts one bus-idle turnaround cycle
//                between tenures.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            in   1        system clock, rising edge
//    rst            in   1        synchronous active-high reset
//    req            in   NUM_REQ  per-master level request
//    grant          out  NUM_REQ  one-hot (or zero) grant, registered
//    owner          out  OWNER_W  index of granted master; holds when idle
//    bus_busy       out  1        |grant, registered with grant
//    timeout_pulse  out  1        one-cycle pulse on a forced release
//    blocked        out  NUM_REQ  masters locked out after forced release
// ============================================================================
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int MAX_TENURE = 16,
  parameter int OWNER_W    = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [OWNER_W-1:0] owner,
  output logic               bus_busy,
  output logic               timeout_pulse,
  output logic [NUM_REQ-1:0] blocked
);

  // A single master has nothing to arbitrate; refuse to build.
  generate
    if (NUM_REQ < 2) begin : g_num_req_check
      $error("bus_arbiter: NUM_REQ must be at least 2");
    end
  endgenerate

  // Tenure counter sized to hold MAX_TENURE (saturation value).
  localparam int CNT_W = (MAX_TENURE < 1) ? 1 : $clog2(MAX_TENURE + 1);
  localparam logic [CNT_W-1:0] TENURE_MAX  = CNT_W'(MAX_TENURE);
  localparam logic [CNT_W-1:0] TENURE_LAST =
      (MAX_TENURE > 0) ? CNT_W'(MAX_TENURE - 1) : '0;
  localparam logic [NUM_REQ-1:0] ONE_BIT = NUM_REQ'(1);

  state_t             state;
  logic [CNT_W-1:0]   tenure;
  logic [OWNER_W-1:0] last;

  logic [NUM_REQ-1:0] eligible;
  logic [OWNER_W-1:0] pick;
  logic               pick_valid;
  logic               timeout_hit;

  assign eligible = req & ~blocked;

  // Counter equal to MAX_TENURE-1 means the current cycle is the last one
  // the owner may hold the bus.
  assign timeout_hit = (MAX_TENURE != 0) && (tenure == TENURE_LAST);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_rr_pick (
    .eligible (eligible),
    .last     (last),
    .pick     (pick),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      owner         <= '0;
      bus_busy      <= 1'b0;
      timeout_pulse <= 1'b0;
      blocked       <= '0;
      tenure        <= '0;
      // Pointer at the top index so master 0 wins the first arbitration.
      last          <= OWNER_W'(NUM_REQ - 1);
    end else begin
      timeout_pulse <= 1'b0;
      // A lockout ends as soon as the master lets go of its request.
      blocked       <= blocked & req;

      case (state)
        // IDLE and TURN arbitrate identically; TURN only exists to
        // guarantee one grant-free cycle after every release.
        IDLE, TURN: begin
          if (pick_valid) begin
            state    <= GRANT;
            grant    <= ONE_BIT << pick;
            owner    <= pick;
            last     <= pick;
            bus_busy <= 1'b1;
            tenure   <= '0;
          end else begin
            state    <= IDLE;
            grant    <= '0;
            bus_busy <= 1'b0;
          end
        end

        GRANT: begin
          if (!req[owner]) begin
            // Voluntary release wins over a coincident timeout.
            state    <= TURN;
            grant    <= '0;
            bus_busy <= 1'b0;
            tenure   <= '0;
          end else if (timeout_hit) begin
            state         <= TURN;
            grant         <= '0;
            bus_busy      <= 1'b0;
            tenure        <= '0;
            timeout_pulse <= 1'b1;
            blocked       <= (blocked & req) | (ONE_BIT << owner);
          end else if (tenure != TENURE_MAX) begin
            tenure <= tenure + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          grant    <= '0;
          bus_busy <= 1'b0;
          tenure   <= '0;
        end
      endcase
    end
  end

  // Structural invariants of the outputs.
  a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
                                    $onehot0(grant));
  a_busy_match   : assert property (@(posedge clk) disable iff (rst)
                                    bus_busy == (|grant));

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. Three instances:
//                a: NUM_REQ=2, MAX_TENURE=4
//                b: NUM_REQ=3, MAX_TENURE=3
//                c: NUM_REQ=2, MAX_TENURE=0 (timeout disabled)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0] req_a = '0, grant_a, blocked_a;
  logic       owner_a, busy_a, pulse_a;
  logic [2:0] req_b = '0, grant_b, blocked_b;
  logic [1:0] owner_b;
  logic       busy_b, pulse_b;
  logic [1:0] req_c = '0, grant_c, blocked_c;
  logic       owner_c, busy_c, pulse_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_REQ(2), .MAX_TENURE(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .owner(owner_a),
    .bus_busy(busy_a), .timeout_pulse(pulse_a), .blocked(blocked_a));

  bus_arbiter #(.NUM_REQ(3), .MAX_TENURE(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .owner(owner_b),
    .bus_busy(busy_b), .timeout_pulse(pulse_b), .blocked(blocked_b));

  bus_arbiter #(.NUM_REQ(2), .MAX_TENURE(0)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .grant(grant_c), .owner(owner_c),
    .bus_busy(busy_c), .timeout_pulse(pulse_c), .blocked(blocked_c));

  // ---------------------------------------------------------------------
  // Reference model: who holds the bus and for how long, in plain terms.
  // ---------------------------------------------------------------------
  typedef struct {
    bit       busy;   // a master currently holds the bus
    int       own;    // current / most recent owner
    int       held;   // cycles the bus has been visible to the owner
    bit       pulse;  // forced release happened at the last edge
    bit [7:0] blk;    // locked-out masters
    int       last;   // most recent winner
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(input int n);
    mdl_t m;
    m.busy = 0; m.own = 0; m.held = 0; m.pulse = 0; m.blk = '0;
    m.last = n - 1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic [7:0] r,
                                    input int n, input int maxt);
    mdl_t nm;
    nm       = m;
    nm.pulse = 0;
    nm.blk   = m.blk & r;
    if (m.busy) begin
      if (!r[m.own]) begin
        nm.busy = 0;
      end else if (maxt > 0 && m.held >= maxt) begin
        nm.busy        = 0;
        nm.pulse       = 1;
        nm.blk[m.own]  = 1'b1;
      end else begin
        nm.held = m.held + 1;
      end
    end else begin
      for (int k = 1; k <= n; k++) begin
        int j;
        j = (m.last + k) % n;
        if (r[j] && !m.blk[j]) begin
          nm.busy = 1; nm.own = j; nm.last = j; nm.held = 1;
          break;
        end
      end
    end
    return nm;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ma = mdl_reset(2);
    mb = mdl_reset(3);
  endtask

  // Table vectors for instance a: req applied, outputs after the next edge.
  typedef struct {
    logic [1:0] req;
    logic [1:0] grant;
    logic       owner;
    logic       busy;
    logic       pulse;
    logic [1:0] blocked;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] eg;
    logic [2:0] exp_g;

    tbl[0]  = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[1]  = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[2]  = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[3]  = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[5]  = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[6]  = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[7]  = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[8]  = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[9]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b11};
    tbl[10] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b11};
    tbl[11] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10};
    tbl[12] = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 2'b10};
    tbl[13] = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};

    // Reset state of all three instances.
    do_reset();
    check("reset_a", {grant_a, owner_a, busy_a, pulse_a, blocked_a}, 0);
    check("reset_b", {grant_b, owner_b, busy_b, pulse_b, blocked_b}, 0);
    check("reset_c", {grant_c, owner_c, busy_c, pulse_c, blocked_c}, 0);

    // Request latency and voluntary release.
    @(posedge clk); @(negedge clk);
    req_a = 2'b01;
    @(posedge clk); @(negedge clk);
    check("latency_grant", {grant_a, owner_a, busy_a}, {2'b01, 1'b0, 1'b1});
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_a = 2'b00;
    @(posedge clk); @(negedge clk);
    check("release_grant", {grant_a, busy_a, pulse_a}, 0);
    @(posedge clk); @(negedge clk);
    check("release_idle", {grant_a, busy_a}, 0);

    // Table: timeout, lockout, turnaround, lockout clearing.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req_a = tbl[i].req;
      @(posedge clk); @(negedge clk);
      check($sformatf("tbl_a[%0d]", i),
            {grant_a, owner_a, busy_a, pulse_a, blocked_a},
            {tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].pulse,
             tbl[i].blocked});
    end

    // Release coinciding with the timeout cycle: no pulse, no lockout.
    do_reset();
    req_a = 2'b01;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("coincide_held", grant_a, 2'b01);
    req_a = 2'b00;
    @(posedge clk); @(negedge clk);
    check("coincide_rel", {grant_a, pulse_a, blocked_a}, 0);
    req_a = 2'b01;
    @(posedge clk); @(negedge clk);
    check("coincide_regrant", grant_a, 2'b01);

    // Round-robin across three masters, each releasing after two cycles.
    do_reset();
    req_b = 3'b111;
    for (int t = 0; t < 4; t++) begin
      exp_g = 3'b001 << (t % 3);
      @(posedge clk); @(negedge clk);
      check($sformatf("rr_first[%0d]", t), grant_b, exp_g);
      @(posedge clk); @(negedge clk);
      check($sformatf("rr_second[%0d]", t), grant_b, exp_g);
      req_b[t % 3] = 1'b0;
      @(posedge clk); @(negedge clk);
      check($sformatf("rr_gap[%0d]", t), {grant_b, busy_b}, 0);
      req_b = 3'b111;
    end

    // Reset during master 1's tenure, with master 0 locked out.
    do_reset();
    req_b = 3'b011;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midrst_before", {grant_b, blocked_b}, {3'b010, 3'b001});
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_after", {grant_b, owner_b, busy_b, pulse_b, blocked_b}, 0);
    rst = 1'b0;
    req_b = 3'b111;
    @(posedge clk); @(negedge clk);
    check("midrst_first", {grant_b, owner_b}, {3'b001, 2'd0});

    // Timeout disabled: a single master keeps the bus indefinitely.
    do_reset();
    req_c = 2'b01;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("notimeout[%0d]", i), {grant_c, pulse_c}, 3'b010);
      @(posedge clk);
    end

    // Randomised traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      eg = ma.busy ? (8'd1 << ma.own) : 8'd0;
      check($sformatf("rand_a[%0d]", i),
            {grant_a, owner_a, busy_a, pulse_a, blocked_a},
            {eg[1:0], ma.own[0], ma.busy, ma.pulse, ma.blk[1:0]});
      eg = mb.busy ? (8'd1 << mb.own) : 8'd0;
      check($sformatf("rand_b[%0d]", i),
            {grant_b, owner_b, busy_b, pulse_b, blocked_b},
            {eg[2:0], mb.own[1:0], mb.busy, mb.pulse, mb.blk[2:0]});
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 3) == 0) req_a[b] = ~req_a[b];
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) req_b[b] = ~req_b[b];
      @(posedge clk);
      ma = mdl_step(ma, {6'b0, req_a}, 2, 4);
      mb = mdl_step(mb, {5'b0, req_b}, 3, 3);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates ownership of the shared system address/data bus between up to NUM_REQ masters: processor core, DMA engine, debug port.
- Uses round-robin priority, a per-tenure timeout, and a mandatory one-cycle turnaround so two masters never drive the bidirectional data bus in the same cycle.
- Sits beside processor_core in the microcontroller top. Its grant and owner outputs steer the address/data bus muxes and tri-state enables.

Parameters:
- NUM_REQ, 2, number of bus masters (2..8); index 0 is the processor core.
- MAX_TENURE, 16, maximum consecutive granted cycles before forced release; 0 disables the timeout.
- OWNER_W, $clog2(NUM_REQ) (minimum 1), width of the owner index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-master bus request, level; held high for the whole transfer.
- grant  output  NUM_REQ  one-hot (or zero) bus grant, registered.
- owner  output  OWNER_W  index of the granted master; holds its last value when no grant.
- bus_busy  output  1  high while any grant bit is high.
- timeout_pulse  output  1  one-cycle pulse when a tenure is force-released.
- blocked  output  NUM_REQ  masters locked out after a forced release, registered.

Behaviour:
- Reset values:
  - grant = 0, owner = 0, bus_busy = 0, timeout_pulse = 0, blocked = 0.
  - Tenure counter = 0, state = IDLE.
  - Round-robin pointer last = NUM_REQ-1, so master 0 wins the first arbitration.
- Reset mid-tenure: all outputs reach their reset values at the next edge. There is no turnaround cycle after reset.
- Eligible masters: eligible = req & ~blocked.
- Pick rule: the first eligible index scanning last+1, last+2, ... modulo NUM_REQ.
- State IDLE:
  - grant = 0.
  - If eligible != 0 at edge N: go to GRANT; grant[pick] = 1 and owner = pick are visible after edge N; last = pick.
  - Latency from req to grant is 1 cycle.
- State GRANT:
  - The tenure counter increments each cycle the grant is held, saturating at MAX_TENURE.
  - Voluntary release: req[owner] sampled low -> go to TURN; grant = 0 after that edge; counter cleared. Setting timeout_pulse is not part of a voluntary release.
  - Forced release: MAX_TENURE != 0, the counter reaches MAX_TENURE-1 and req[owner] is still high -> go to TURN; grant = 0; timeout_pulse = 1 for exactly one cycle; blocked[owner] set.
  - The granted master therefore holds the bus for at most MAX_TENURE cycles.
  - If req[owner] drops in the same cycle the timeout would fire, it is a voluntary release: no pulse, no block.
- State TURN:
  - Exactly one cycle with grant = 0; arbitration is evaluated in this cycle.
  - If eligible != 0: go to GRANT with the new pick. Otherwise go to IDLE.
  - Gap between release sampled and the next grant is 2 edges (one bus-idle cycle).
- Blocking:
  - blocked[i] clears on the first cycle req[i] is sampled low.
  - A blocked master that keeps req high is never granted.
- Other masters' req changes during GRANT are ignored; there is no preemption.
- bus_busy = |grant, registered together with grant.
- An X or glitch on req of a non-owner has no effect until the next arbitration point.
- NUM_REQ = 1 is not supported; elaboration fails (assert) if NUM_REQ < 2.

Decomposition:
- Shared package bus_pkg holds:
  - the state enum {IDLE, GRANT, TURN};
  - ADDR_W = 16 and DATA_W = 8 (system bus widths);
  - the I/O bank base address 16'h02.
- One combinational sub-module, rr_pick:
  - inputs: eligible vector and last pointer;
  - outputs: pick index and valid;
  - implemented as rotate, find-first, un-rotate.
- The FSM, tenure counter, and blocked register stay in bus_arbiter.

Test Plan:
- Reset, then req = 2'b01 at cycle 3 -> grant = 01 and owner = 0 at cycle 4; bus_busy = 1; req drop at cycle 8 -> grant = 00 at cycle 9, state IDLE at cycle 10.
- req = 2'b11 held continuously, MAX_TENURE = 4:
  - master 0 granted 4 cycles, then timeout_pulse = 1 and one TURN cycle;
  - master 1 granted 4 cycles;
  - master 0 stays locked out (blocked[0] = 1) until it drops req.
- Round-robin with NUM_REQ = 3, all requesting, each releasing after 2 cycles -> grant order 0, 1, 2, 0 with exactly one grant = 0 cycle between tenures.
- Release and timeout in the same cycle (req[owner] drops when the counter reaches MAX_TENURE-1) -> no timeout_pulse, blocked unchanged.
- Assert rst during master 1's tenure -> grant = 0, owner = 0, blocked = 0 next edge; the next arbitration grants master 0 first.
- MAX_TENURE = 0, single master holding req for 100 cycles -> grant never drops, timeout_pulse never asserts.
